// File: rtl/down_counter_timer.sv
// Loadable down-counter timer with one-shot and periodic (auto-reload) modes.
// Three-state FSM (IDLE/RUN/DONE) with a registered one-cycle terminal-count pulse.
module down_counter_timer #(
    parameter int COUNT_WIDTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   enable,
    input  logic                   load,
    input  logic [COUNT_WIDTH-1:0] load_value,
    input  logic                   auto_reload,
    output logic [COUNT_WIDTH-1:0] count,
    output logic                   busy,
    output logic                   done,
    output logic                   tc
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [COUNT_WIDTH-1:0] ONE = COUNT_WIDTH'(1);

    state_t                 state, state_nxt;
    logic [COUNT_WIDTH-1:0] reload_reg, reload_nxt;
    logic [COUNT_WIDTH-1:0] count_nxt;
    logic                   tc_nxt;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            count      <= '0;
            reload_reg <= '0;
            tc         <= 1'b0;
        end else begin
            state      <= state_nxt;
            count      <= count_nxt;
            reload_reg <= reload_nxt;
            tc         <= tc_nxt;
        end
    end

    // NOTE: every output of this block is given a default first so that no
    // path through the case statement leaves a value unassigned (no latches).
    always_comb begin
        state_nxt  = state;
        count_nxt  = count;
        reload_nxt = reload_reg;
        tc_nxt     = 1'b0;

        if (load) begin
            // A load beats everything, including a coincident terminal count.
            count_nxt  = load_value;
            reload_nxt = load_value;
            state_nxt  = (load_value != '0) ? RUN : IDLE;
        end else begin
            unique case (state)
                IDLE: ;
                RUN: begin
                    if (enable) begin
                        if (count > ONE) begin
                            count_nxt = count - ONE;
                        end else if (count == ONE) begin
                            tc_nxt = 1'b1;
                            if (auto_reload) begin
                                count_nxt = reload_reg;
                            end else begin
                                count_nxt = '0;
                                state_nxt = DONE;
                            end
                        end else begin
                            // Unreachable: RUN is only entered with a nonzero count.
                            state_nxt = IDLE;
                        end
                    end
                end
                DONE: count_nxt = '0;
                default: begin
                    state_nxt = IDLE;
                    count_nxt = '0;
                end
            endcase
        end
    end

    assign busy = (state == RUN);
    assign done = (state == DONE);

endmodule

// File: tb/tb_down_counter_timer.sv
// Scoreboard bench for down_counter_timer: stimulus pushes expected outputs,
// a monitor process pops and compares one cycle later (or at once for resets).
module tb_down_counter_timer;

    localparam int W = 4;

    typedef struct {
        logic [W-1:0] count;
        logic         busy;
        logic         done;
        logic         tc;
        bit           async;
        string        name;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         enable;
    logic         load;
    logic [W-1:0] load_value;
    logic         auto_reload;
    logic [W-1:0] count;
    logic         busy;
    logic         done;
    logic         tc;

    exp_t sb[$];
    int   vectors     = 0;
    int   miscompares = 0;

    down_counter_timer #(.COUNT_WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .load        (load),
        .load_value  (load_value),
        .auto_reload (auto_reload),
        .count       (count),
        .busy        (busy),
        .done        (done),
        .tc          (tc)
    );

    always #5 clk = ~clk;

    task automatic push_exp(input logic [W-1:0] ec, input logic eb, input logic ed,
                            input logic et, input bit as, input string nm);
        exp_t e;
        e.count = ec; e.busy = eb; e.done = ed; e.tc = et; e.async = as; e.name = nm;
        sb.push_back(e);
    endtask

    // Called at posedge+2: drive inputs, record what the next edge must produce.
    task automatic step(input logic ld, input logic [W-1:0] lv, input logic en,
                        input logic ar, input logic [W-1:0] ec, input logic eb,
                        input logic ed, input logic et, input string nm);
        load = ld; load_value = lv; enable = en; auto_reload = ar;
        push_exp(ec, eb, ed, et, 1'b0, nm);
        @(posedge clk);
        #2;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            wait (sb.size() != 0);
            e = sb[0];
            if (e.async) #1;
            else begin
                @(posedge clk);
                #1;
            end
            e = sb.pop_front();
            vectors++;
            if (count !== e.count || busy !== e.busy || done !== e.done || tc !== e.tc) begin
                miscompares++;
                $display("FAIL %s: got count=%0d busy=%b done=%b tc=%b, want count=%0d busy=%b done=%b tc=%b",
                         e.name, count, busy, done, tc, e.count, e.busy, e.done, e.tc);
            end
        end
    end

    initial begin : stimulus
        rst = 1'b1; load = 1'b0; load_value = '0; enable = 1'b0; auto_reload = 1'b0;
        #1;
        push_exp(4'd0, 1'b0, 1'b0, 1'b0, 1'b1, "reset_state");
        @(posedge clk);
        #2;
        rst = 1'b0;

        // One-shot from 5
        step(1, 4'd5, 1, 0, 4'd5, 1, 0, 0, "os_load5");
        step(0, 4'd0, 1, 0, 4'd4, 1, 0, 0, "os_4");
        step(0, 4'd0, 1, 0, 4'd3, 1, 0, 0, "os_3");
        step(0, 4'd0, 1, 0, 4'd2, 1, 0, 0, "os_2");
        step(0, 4'd0, 1, 0, 4'd1, 1, 0, 0, "os_1");
        step(0, 4'd0, 1, 0, 4'd0, 0, 1, 1, "os_tc");
        step(0, 4'd0, 1, 0, 4'd0, 0, 1, 0, "os_done_hold");
        step(0, 4'd0, 1, 1, 4'd0, 0, 1, 0, "os_done_ignore_en");

        // Periodic from 3
        step(1, 4'd3, 1, 1, 4'd3, 1, 0, 0, "per_load3");
        step(0, 4'd0, 1, 1, 4'd2, 1, 0, 0, "per_2a");
        step(0, 4'd0, 1, 1, 4'd1, 1, 0, 0, "per_1a");
        step(0, 4'd0, 1, 1, 4'd3, 1, 0, 1, "per_reload_a");
        step(0, 4'd0, 1, 1, 4'd2, 1, 0, 0, "per_2b");
        step(0, 4'd0, 1, 1, 4'd1, 1, 0, 0, "per_1b");
        step(0, 4'd0, 1, 1, 4'd3, 1, 0, 1, "per_reload_b");

        // Hold with enable 1,0,0,1 from 4
        step(1, 4'd4, 0, 0, 4'd4, 1, 0, 0, "hold_load4");
        step(0, 4'd0, 1, 0, 4'd3, 1, 0, 0, "hold_en1");
        step(0, 4'd0, 0, 0, 4'd3, 1, 0, 0, "hold_en0a");
        step(0, 4'd0, 0, 0, 4'd3, 1, 0, 0, "hold_en0b");
        step(0, 4'd0, 1, 0, 4'd2, 1, 0, 0, "hold_en1b");

        // Zero load lands in IDLE, enable ignored there
        step(1, 4'd0, 1, 0, 4'd0, 0, 0, 0, "zero_load");
        step(0, 4'd0, 1, 0, 4'd0, 0, 0, 0, "idle_ignore_en");

        // Load colliding with terminal count
        step(1, 4'd2, 1, 0, 4'd2, 1, 0, 0, "col_load2");
        step(0, 4'd0, 1, 0, 4'd1, 1, 0, 0, "col_1");
        step(1, 4'd9, 1, 0, 4'd9, 1, 0, 0, "col_load9_wins");
        step(0, 4'd0, 1, 0, 4'd8, 1, 0, 0, "col_8");

        // Reload value 1 in periodic mode
        step(1, 4'd1, 1, 1, 4'd1, 1, 0, 0, "r1_load1");
        step(0, 4'd0, 1, 1, 4'd1, 1, 0, 1, "r1_tc_a");
        step(0, 4'd0, 1, 1, 4'd1, 1, 0, 1, "r1_tc_b");
        step(0, 4'd0, 0, 1, 4'd1, 1, 0, 0, "r1_hold");

        // Asynchronous reset mid-count
        step(1, 4'd6, 1, 0, 4'd6, 1, 0, 0, "ar_load6");
        load = 1'b0; enable = 1'b1;
        #1;
        rst = 1'b1;
        push_exp(4'd0, 1'b0, 1'b0, 1'b0, 1'b1, "ar_async_clear");
        #2;
        rst = 1'b0;
        step(0, 4'd0, 1, 0, 4'd0, 0, 0, 0, "ar_post_release_idle");
        step(0, 4'd0, 1, 0, 4'd0, 0, 0, 0, "ar_still_idle");

        // Upper boundary: 15 enabled cycles to tc, no wrap afterwards
        step(1, 4'd15, 1, 0, 4'd15, 1, 0, 0, "max_load15");
        for (int i = 14; i >= 1; i--)
            step(0, 4'd0, 1, 0, W'(i), 1, 0, 0, $sformatf("max_%0d", i));
        step(0, 4'd0, 1, 0, 4'd0, 0, 1, 1, "max_tc");
        step(0, 4'd0, 1, 0, 4'd0, 0, 1, 0, "max_no_wrap_a");
        step(0, 4'd0, 1, 1, 4'd0, 0, 1, 0, "max_no_wrap_b");

        // Leave DONE through a load
        step(1, 4'd2, 1, 0, 4'd2, 1, 0, 0, "done_reload");

        repeat (3) @(posedge clk);
        #3;
        if (sb.size() != 0) begin
            miscompares += sb.size();
            $display("FAIL drain: %0d expectations left, required 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
